// File: rtl/gc_dram_pkg.sv
// Shared types and constants for the GC-DRAM refresh logic.
package gc_dram_pkg;
    localparam int unsigned ROW_AW         = 7;
    localparam int unsigned PTR_W          = ROW_AW + 1;
    localparam int unsigned ROWS_DEFAULT   = 128;
    localparam int unsigned PERIOD_DEFAULT = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_RD,
        ST_WB,
        ST_DONE
    } state_t;
endpackage

// File: rtl/next_row_finder.sv
// Combinational priority encoder: lowest clear bitmap bit at or above the pointer.
module next_row_finder
    import gc_dram_pkg::*;
#(
    parameter int unsigned ROWS = ROWS_DEFAULT
) (
    input  logic [ROWS-1:0]   i_bitmap,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic              o_found_c,
    output logic [ROW_AW-1:0] o_row_c
);

    // Walk downwards so the lowest qualifying index is the last one written.
    always_comb begin
        o_found_c = 1'b0;
        o_row_c   = '0;
        for (int i = int'(ROWS) - 1; i >= 0; i--) begin
            if (!i_bitmap[i] && (PTR_W'(i) >= i_ptr)) begin
                o_found_c = 1'b1;
                o_row_c   = ROW_AW'(i);
            end
        end
    end

endmodule

// File: rtl/refresh_scheduler.sv
// Periodic GC-DRAM refresh sweep with user-write skipping.
// Optional sticky overrun flag enabled by defining REFRESH_OVERRUN_EN.
module refresh_scheduler
    import gc_dram_pkg::*;
#(
    parameter int unsigned ROWS   = ROWS_DEFAULT,
    parameter int unsigned PERIOD = PERIOD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pause,
    input  logic              wr_valid,
    input  logic [ROW_AW-1:0] wr_addr,
    output logic              ref_req,
    output logic              ref_we,
    output logic [ROW_AW-1:0] ref_addr,
    input  logic              ref_ack,
    output logic              busy,
    output logic              sweep_done
`ifdef REFRESH_OVERRUN_EN
    ,
    output logic              overrun
`endif
);

    localparam int unsigned IDX_W = $clog2(ROWS);
    localparam int unsigned TMR_W = $clog2(PERIOD);

    state_t            r_state;
    logic [ROWS-1:0]   r_fresh;
    logic [PTR_W-1:0]  r_ptr;
    logic [TMR_W-1:0]  r_timer;
    logic              r_req;
    logic              r_we;
    logic [ROW_AW-1:0] r_addr;
    logic              r_busy;
    logic              r_done;

    logic              w_expiry;
    logic              w_found;
    logic [ROW_AW-1:0] w_row;
    logic [ROWS-1:0]   w_wr_mask;
    logic [ROWS-1:0]   w_ack_mask;

    assign w_expiry = (r_timer == '0);

    // Out-of-range write addresses produce an empty mask.
    always_comb begin
        w_wr_mask  = '0;
        w_ack_mask = '0;
        if (wr_valid && (32'(wr_addr) < ROWS)) begin
            w_wr_mask[wr_addr[IDX_W-1:0]] = 1'b1;
        end
        w_ack_mask[r_addr[IDX_W-1:0]] = 1'b1;
    end

    next_row_finder #(
        .ROWS (ROWS)
    ) u_finder (
        .i_bitmap  (r_fresh),
        .i_ptr     (r_ptr),
        .o_found_c (w_found),
        .o_row_c   (w_row)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= TMR_W'(PERIOD - 1);
        end else if (w_expiry) begin
            r_timer <= TMR_W'(PERIOD - 1);
        end else begin
            r_timer <= r_timer - TMR_W'(1);
        end
    end

    // Sweep FSM; the user-write mask is merged into the bitmap every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_fresh <= '0;
            r_ptr   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_fresh <= r_fresh | w_wr_mask;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_expiry) begin
                        r_fresh <= w_wr_mask;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!w_found) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (!pause) begin
                        r_addr  <= w_row;
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (ref_ack) begin
                        r_we    <= 1'b1;
                        r_state <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (ref_ack) begin
                        r_fresh <= r_fresh | w_wr_mask | w_ack_mask;
                        r_ptr   <= PTR_W'(r_addr) + PTR_W'(1);
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= ST_SCAN;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ref_req    = r_req;
    assign ref_we     = r_we;
    assign ref_addr   = r_addr;
    assign busy       = r_busy;
    assign sweep_done = r_done;

`ifdef REFRESH_OVERRUN_EN
    logic r_overrun;

    // A retention deadline passing mid-sweep is latched until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_expiry && r_busy) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`endif

endmodule

// File: tb/tb_refresh_scheduler.sv
// Bench for refresh_scheduler (ROWS=8, PERIOD=64) with a sweep-level reference model.
// Define REFRESH_OVERRUN_EN to also check the overrun flag.
module tb_refresh_scheduler;
    localparam int ROWS   = 8;
    localparam int PERIOD = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0;
    logic       wr_valid = 1'b0;
    logic [6:0] wr_addr = '0;
    logic       ref_req;
    logic       ref_we;
    logic [6:0] ref_addr;
    logic       ref_ack = 1'b0;
    logic       busy;
    logic       sweep_done;
`ifdef REFRESH_OVERRUN_EN
    logic       overrun;
`endif

    refresh_scheduler #(
        .ROWS   (ROWS),
        .PERIOD (PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pause      (pause),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .ref_req    (ref_req),
        .ref_we     (ref_we),
        .ref_addr   (ref_addr),
        .ref_ack    (ref_ack),
        .busy       (busy),
        .sweep_done (sweep_done)
`ifdef REFRESH_OVERRUN_EN
        ,
        .overrun    (overrun)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: which rows count as fresh, where the sweep resumes,
    // and the clock edges elapsed since reset release.
    bit fresh_m [ROWS];
    int mptr;
    int ecount;
    bit m_busy;
    bit m_done_pending;
    bit m_overrun;
    int op_addrs[$];
    int last_ops[$];
    int done_cnt;
    int ack_delay;
    int wait_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int find_cand();
        for (int r = mptr; r < ROWS; r++) begin
            if (!fresh_m[r]) return r;
        end
        return ROWS;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++) fresh_m[r] = 1'b0;
        mptr = 0; ecount = 0; m_busy = 0; m_done_pending = 0; m_overrun = 0;
        op_addrs.delete(); wait_cnt = 0;
    endtask

    // One clock: apply the edge to the model, sample DUT, check, then answer ref_req.
    task automatic tick();
        logic       drove_wr, drove_pause, ack_b, req_b, we_b, old_busy;
        logic [6:0] wa, addr_b;
        int         cand_pre;
        drove_wr = wr_valid; wa = wr_addr; drove_pause = pause; ack_b = ref_ack;
        req_b = ref_req; we_b = ref_we; addr_b = ref_addr;
        cand_pre = find_cand();
        @(posedge clk);
        ecount++;
        old_busy = m_busy;
        if (m_done_pending) begin m_busy = 0; m_done_pending = 0; end
        if (ecount % PERIOD == 0) begin
            if (old_busy) m_overrun = 1;
            else begin
                for (int r = 0; r < ROWS; r++) fresh_m[r] = 1'b0;
                mptr = 0; m_busy = 1; op_addrs.delete();
            end
        end
        if (drove_wr && int'(wa) < ROWS) fresh_m[wa] = 1'b1;
        if (ack_b && req_b && we_b) begin
            fresh_m[addr_b] = 1'b1;
            mptr = int'(addr_b) + 1;
        end
        #1;
        chk("busy", busy, m_busy);
        if (!m_busy) chk("idle_no_req", ref_req, 0);
        if (!req_b && drove_pause) chk("pause_block", ref_req, 0);
        if (req_b && !ack_b) begin
            chk("stable_req", ref_req, req_b);
            chk("stable_we", ref_we, we_b);
            chk("stable_addr", ref_addr, addr_b);
        end
        if (req_b && ack_b && !we_b) begin
            chk("wb_req", ref_req, 1);
            chk("wb_we", ref_we, 1);
            chk("wb_addr", ref_addr, addr_b);
        end
        if (ref_req && !req_b) begin
            chk("rd_we", ref_we, 0);
            chk("rd_addr", ref_addr, cand_pre);
            op_addrs.push_back(int'(ref_addr));
        end
        if (sweep_done) begin
            chk("done_no_cand", cand_pre, ROWS);
            m_done_pending = 1;
            last_ops = op_addrs;
            done_cnt++;
        end
`ifdef REFRESH_OVERRUN_EN
        chk("overrun", overrun, m_overrun);
`endif
        if (ref_ack) wait_cnt = 0;
        ref_ack = 1'b0;
        if (ref_req) begin
            wait_cnt++;
            if (wait_cnt > ack_delay) ref_ack = 1'b1;
        end
    endtask

    task automatic run_until_done(input string tag, input int bound);
        int start;
        start = done_cnt;
        for (int i = 0; i < bound && done_cnt == start; i++) tick();
        chk(tag, done_cnt - start, 1);
        tick();
    endtask

    task automatic wait_busy(input string tag, input int bound);
        for (int i = 0; i < bound && !busy; i++) tick();
        chk(tag, busy, 1);
    endtask

    task automatic check_ops(input string tag, input int exp_q[$]);
        chk({tag, "_count"}, last_ops.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < last_ops.size()) chk({tag, "_addr"}, last_ops[i], exp_q[i]);
        end
    endtask

    initial begin
        int q[$];
        int n;
        ack_delay = 0; done_cnt = 0;
        model_reset();

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", ref_req, 0);
        chk("rst_we", ref_we, 0);
        chk("rst_addr", ref_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", sweep_done, 0);
`ifdef REFRESH_OVERRUN_EN
        chk("rst_overrun", overrun, 0);
`endif
        rst = 1'b0;

        // Plain sweep: rows 0..7 in order.
        run_until_done("sweep1_done", 3 * PERIOD);
        q = {0, 1, 2, 3, 4, 5, 6, 7};
        check_ops("sweep1", q);

        // Writes before expiry are wiped; a write to row 3 mid-sweep skips it.
        wr_valid = 1'b1; wr_addr = 7'd2; tick();
        wr_addr = 7'd5; tick();
        wr_valid = 1'b0;
        wait_busy("sweep2_start", 2 * PERIOD);
        wr_valid = 1'b1; wr_addr = 7'd3; tick();
        wr_valid = 1'b0;
        run_until_done("sweep2_done", 2 * PERIOD);
        q = {0, 1, 2, 4, 5, 6, 7};
        check_ops("sweep2", q);

        // Write on the clearing edge survives; out-of-range address is ignored.
        for (int i = 0; i < 2 * PERIOD && ((ecount + 1) % PERIOD) != 0; i++) tick();
        wr_valid = 1'b1; wr_addr = 7'd4; tick();
        wr_addr = 7'd13; tick();
        wr_valid = 1'b0;
        run_until_done("sweep3_done", 2 * PERIOD);
        q = {0, 1, 2, 3, 5, 6, 7};
        check_ops("sweep3", q);

        // Pause in SCAN blocks issue; pause during RD does not abort the pair.
        wait_busy("sweep4_start", 2 * PERIOD);
        pause = 1'b1;
        repeat (10) begin
            tick();
            chk("pause_hold", ref_req, 0);
        end
        pause = 1'b0;
        for (int i = 0; i < 20 && !(ref_req && !ref_we); i++) tick();
        chk("pause_rd_seen", ref_req, 1);
        pause = 1'b1;
        tick();
        chk("pause_rd_wb_req", ref_req, 1);
        chk("pause_rd_wb_we", ref_we, 1);
        tick();
        tick();
        chk("pause_after_pair", ref_req, 0);
        pause = 1'b0;
        run_until_done("sweep4_done", 2 * PERIOD);
        q = {0, 1, 2, 3, 4, 5, 6, 7};
        check_ops("sweep4", q);

        // Random pause/write/ack-latency traffic against the model.
        for (int i = 0; i < 3 * PERIOD; i++) begin
            pause     = ($urandom_range(0, 3) == 0);
            wr_valid  = ($urandom_range(0, 4) == 0);
            wr_addr   = 7'($urandom_range(0, 15));
            ack_delay = $urandom_range(0, 1);
            tick();
        end
        pause = 1'b0; wr_valid = 1'b0; ack_delay = 0;
        for (int i = 0; i < 4 * PERIOD && m_busy; i++) tick();
        chk("rand_settle", busy, 0);

        // Slow array: expiry during a sweep must not restart it.
        wait_busy("sweep5_start", 2 * PERIOD);
        ack_delay = 100;
        repeat (PERIOD + 4) tick();
        chk("no_restart_busy", busy, 1);
`ifdef REFRESH_OVERRUN_EN
        chk("overrun_set", overrun, 1);
`endif
        ack_delay = 0;
        run_until_done("sweep5_done", 4 * PERIOD);
        q = {0, 1, 2, 3, 4, 5, 6, 7};
        check_ops("sweep5", q);

        // Reset while in write-back.
        wait_busy("sweep6_start", 2 * PERIOD);
        for (int i = 0; i < 50 && !(ref_req && ref_we); i++) tick();
        chk("wb_reached", ref_we, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_wb_req", ref_req, 0);
        chk("rst_wb_busy", busy, 0);
        chk("rst_wb_we", ref_we, 0);
        chk("rst_wb_addr", ref_addr, 0);
`ifdef REFRESH_OVERRUN_EN
        chk("rst_wb_overrun", overrun, 0);
`endif
        ref_ack = 1'b0; pause = 1'b0; wr_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        n = 0;
        while (!busy && n < 2 * PERIOD) begin
            tick();
            n++;
        end
        chk("restart_latency", n, PERIOD);
        run_until_done("sweep7_done", 2 * PERIOD);
        q = {0, 1, 2, 3, 4, 5, 6, 7};
        check_ops("sweep7", q);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/refresh_scheduler.md
REFRESH_SCHEDULER -- requirements
Module: refresh_scheduler

Interface
REQ-001 Parameter ROWS, default 128, number of GC-DRAM rows (power of two, 2..128).
REQ-002 Parameter PERIOD, default 4096, retention interval in clk cycles between sweep starts (>= 2*ROWS).
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 pause  in  1  user access in progress; blocks issue of new refresh operations.
REQ-006 wr_valid  in  1  user write this cycle, which refreshes the row at wr_addr.
REQ-007 wr_addr  in  7  row written by the user.
REQ-008 ref_req  out  1  refresh operation request to the array.
REQ-009 ref_we  out  1  0 = read phase, 1 = write-back phase.
REQ-010 ref_addr  out  7  row under refresh.
REQ-011 ref_ack  in  1  array completed the current phase.
REQ-012 busy  out  1  sweep in progress.
REQ-013 sweep_done  out  1  one-cycle pulse when a sweep completes.

Function
REQ-014 Internal ROWS-bit fresh bitmap; bit set = row needs no refresh in the current sweep.
REQ-015 Down-counter timer loads PERIOD-1 at reset and on reaching 0; an expiry event occurs when it reaches 0.
REQ-016 FSM states: IDLE, SCAN, RD, WB, DONE; reset state IDLE.
REQ-017 IDLE -> SCAN on expiry; bitmap cleared on the same edge; busy=1 from the next cycle.
REQ-018 SCAN: lowest-index clear bit at or above scan pointer selected; if none, -> DONE; if found and pause=0, ref_addr<=row, -> RD; if pause=1, stay in SCAN.
REQ-019 RD: ref_req=1, ref_we=0; on ref_ack -> WB.
REQ-020 WB: ref_req=1, ref_we=1; on ref_ack, set bitmap[ref_addr], pointer<=ref_addr+1, -> SCAN.
REQ-021 ref_req, ref_we and ref_addr shall stay stable from assertion until ref_ack; pause shall not abort an operation in RD or WB.
REQ-022 DONE: sweep_done=1 for one cycle, busy=0 afterwards, -> IDLE.
REQ-023 wr_valid sets bitmap[wr_addr] every cycle, including when rows are already set; on the clear edge of REQ-017, a simultaneous wr_valid bit survives (set wins).
REQ-024 Pointer wrap: a pointer equal to ROWS means no candidates remain (-> DONE); wr_addr >= ROWS is ignored.
REQ-025 Expiry while busy shall not restart the sweep.

Reset
REQ-026 On rst: state IDLE, bitmap cleared, pointer 0, timer PERIOD-1, ref_req=0, ref_we=0, ref_addr=0, busy=0, sweep_done=0.
REQ-027 rst asserted mid-operation shall drop ref_req in the same cycle; no state survives.

Configuration
REQ-028 With macro REFRESH_OVERRUN_EN defined, add output overrun (1 bit): it is set sticky when expiry occurs while busy=1, and it is cleared only by rst.
REQ-029 Without REFRESH_OVERRUN_EN, the overrun port and its logic are absent; expiry while busy is silently ignored per REQ-025.

Structure
REQ-030 Shared package gc_dram_pkg holds the FSM state enum, ROW_AW=7, and the default ROWS and PERIOD constants.
REQ-031 One sub-module, next_row_finder: a combinational priority encoder that takes the bitmap and pointer and outputs found and row.

Verification
REQ-032 Bench uses ROWS=8, PERIOD=64, ref_ack one cycle after each ref_req, and no writes -> 8 RD/WB pairs with addr 0..7 in order, followed by one sweep_done pulse.
REQ-033 Before expiry, wr_valid is driven for rows 2 and 5 -> they are not set, because the sweep clears the bitmap; a write to row 3 during the sweep before the pointer reaches it -> row 3 is skipped, giving 7 refreshes.
REQ-034 pause=1 held 10 cycles while in SCAN -> ref_req stays 0; pause asserted during RD -> the RD/WB pair completes unchanged.
REQ-035 ref_ack delayed 100 cycles with REFRESH_OVERRUN_EN -> overrun=1 after the next expiry, and the sweep is not restarted.
REQ-036 rst pulse while in WB -> ref_req=0 immediately, busy=0, and the next sweep starts PERIOD cycles after rst release at row 0.
